// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS memory-bus arbiter.
//   bus_arb_state_t : arbiter FSM states
//   master_id_t     : bus master identity (fetch = I, data = D)
//   RESET_VECTOR    : CPU boot address, first fetch target
//   rr_pick         : round-robin choice between the two request lines
package mips_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY_I,
        ST_BUSY_D,
        ST_RDATA_I,
        ST_RDATA_D
    } bus_arb_state_t;

    typedef enum logic {
        MASTER_I = 1'b0,
        MASTER_D = 1'b1
    } master_id_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    // On a tie the master that did not win last time is chosen; a lone
    // requester always wins. With no request the result is unused.
    function automatic master_id_t rr_pick(input logic req_i, input logic req_d,
                                           input master_id_t last);
        if (req_i && req_d)
            return (last == MASTER_D) ? MASTER_I : MASTER_D;
        else if (req_d)
            return MASTER_D;
        return MASTER_I;
    endfunction

endpackage

// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter sharing one Avalon-style memory bus
// between the instruction-fetch master (i_*) and the data master (d_*).
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_* / d_*           : master-side request (read, write, address,
//                         writedata, byteenable) and response
//                         (waitrequest, readdata, readdatavalid)
//   address, read, write, writedata, byteenable : slave-side request
//   waitrequest, readdata                       : slave-side response;
//                         readdata is valid the cycle after a read is accepted
//
// Every transfer is: one IDLE cycle for arbitration, BUSY_x until the slave
// drops waitrequest, and for reads one RDATA_x cycle carrying the data.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_read,
    input  logic                i_write,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic [DATA_W-1:0]   i_writedata,
    input  logic [DATA_W/8-1:0] i_byteenable,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_readdatavalid,

    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_readdatavalid,

    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata
);

    bus_arb_state_t state, state_next;
    master_id_t     last, last_next;
    master_id_t     pick;
    logic           req_i, req_d;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            last  <= MASTER_D;   // fetch wins the first tie
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_next       = last;
        pick            = rr_pick(req_i, req_d, last);
        address         = '0;
        read            = 1'b0;
        write           = 1'b0;
        writedata       = '0;
        byteenable      = '0;
        i_waitrequest   = 1'b1;
        d_waitrequest   = 1'b1;
        i_readdata      = '0;
        d_readdata      = '0;
        i_readdatavalid = 1'b0;
        d_readdatavalid = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_i || req_d) begin
                    last_next  = pick;
                    state_next = (pick == MASTER_I) ? ST_BUSY_I : ST_BUSY_D;
                end
            end

            // Write takes precedence when a master raises both strobes.
            ST_BUSY_I: begin
                address       = i_address;
                write         = i_write;
                read          = i_read & ~i_write;
                writedata     = i_writedata;
                byteenable    = i_byteenable;
                i_waitrequest = waitrequest;
                if (!waitrequest)
                    state_next = i_write ? ST_IDLE : ST_RDATA_I;
            end

            ST_BUSY_D: begin
                address       = d_address;
                write         = d_write;
                read          = d_read & ~d_write;
                writedata     = d_writedata;
                byteenable    = d_byteenable;
                d_waitrequest = waitrequest;
                if (!waitrequest)
                    state_next = d_write ? ST_IDLE : ST_RDATA_D;
            end

            ST_RDATA_I: begin
                i_readdata      = readdata;
                i_readdatavalid = 1'b1;
                state_next      = ST_IDLE;
            end

            ST_RDATA_D: begin
                d_readdata      = readdata;
                d_readdatavalid = 1'b1;
                state_next      = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level model of the shared bus.
module tb_mips_bus_arbiter;
    import mips_bus_pkg::*;

    logic        clk, reset;
    logic        i_read, i_write, d_read, d_write;
    logic [31:0] i_address, i_writedata, d_address, d_writedata;
    logic [3:0]  i_byteenable, d_byteenable;
    logic        i_waitrequest, d_waitrequest, i_readdatavalid, d_readdatavalid;
    logic [31:0] i_readdata, d_readdata;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;

    int tests = 0;
    int fails = 0;

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_address(i_address),
        .i_writedata(i_writedata), .i_byteenable(i_byteenable),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .i_readdatavalid(i_readdatavalid),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .d_readdatavalid(d_readdatavalid),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Transaction model state
    typedef struct {
        bit          wr;
        bit          both;   // read strobe also raised on a write
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    txn_t q_i[$];
    txn_t q_d[$];
    bit   act[2];        // master currently presenting its head request
    int   cur;           // master owning the bus transfer, -1 none
    int   rd;            // master due read data this cycle, -1 none
    int   mlast;         // last granted master
    int   dut_grants[$]; // accepting master seen on the DUT, in order

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masters();
        i_read = 0; i_write = 0; i_address = 0; i_writedata = 0; i_byteenable = 0;
        d_read = 0; d_write = 0; d_address = 0; d_writedata = 0; d_byteenable = 0;
    endtask

    task automatic do_reset();
        clear_masters();
        waitrequest = 0;
        readdata = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
        cur = -1; rd = -1; mlast = 1;
        act[0] = 0; act[1] = 0;
        q_i.delete(); q_d.delete(); dut_grants.delete();
    endtask

    function automatic txn_t rand_txn(input int m);
        txn_t t;
        t.wr   = ($urandom_range(0, 1) == 1);
        t.both = t.wr && ($urandom_range(0, 3) == 0);
        t.addr = (m == 0) ? RESET_VECTOR + 32'($urandom_range(0, 255) * 4) : $urandom;
        t.data = $urandom;
        t.be   = 4'($urandom);
        return t;
    endfunction

    function automatic txn_t head(input int m);
        return (m == 0) ? q_i[0] : q_d[0];
    endfunction

    task automatic drive_masters();
        txn_t t;
        if (act[0]) begin
            t = q_i[0];
            i_read = !t.wr || t.both; i_write = t.wr; i_address = t.addr;
            i_writedata = t.data; i_byteenable = t.be;
        end else begin
            i_read = 0; i_write = 0; i_address = $urandom;
            i_writedata = $urandom; i_byteenable = 4'($urandom);
        end
        if (act[1]) begin
            t = q_d[0];
            d_read = !t.wr || t.both; d_write = t.wr; d_address = t.addr;
            d_writedata = t.data; d_byteenable = t.be;
        end else begin
            d_read = 0; d_write = 0; d_address = $urandom;
            d_writedata = $urandom; d_byteenable = 4'($urandom);
        end
    endtask

    // Runs the queued transactions through the DUT, checking every cycle.
    task automatic run_engine(input int stall_pct, input bit always_req, input int max_cycles);
        txn_t        t;
        int          cyc;
        logic        e_rd, e_wr, e_iw, e_dw, e_iv, e_dv;
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
        logic [3:0]  e_be;
        cyc = 0;
        while ((q_i.size() > 0 || q_d.size() > 0 || cur >= 0 || rd >= 0) && cyc < max_cycles) begin
            for (int m = 0; m < 2; m++)
                if (!act[m] && ((m == 0) ? q_i.size() : q_d.size()) > 0 &&
                    (always_req || $urandom_range(0, 2) != 0))
                    act[m] = 1;
            drive_masters();
            waitrequest = ($urandom_range(0, 99) < stall_pct);
            readdata = $urandom;
            #1;
            e_rd = 0; e_wr = 0; e_addr = 0; e_wd = 0; e_be = 0;
            e_iw = 1; e_dw = 1; e_iv = 0; e_dv = 0; e_ird = 0; e_drd = 0;
            if (cur >= 0) begin
                t = head(cur);
                e_wr = t.wr; e_rd = !t.wr; e_addr = t.addr; e_wd = t.data; e_be = t.be;
                if (cur == 0) e_iw = waitrequest; else e_dw = waitrequest;
            end
            if (rd == 0) begin e_iv = 1; e_ird = readdata; end
            if (rd == 1) begin e_dv = 1; e_drd = readdata; end
            if ({read, write, address, writedata, byteenable} !== {e_rd, e_wr, e_addr, e_wd, e_be}) begin
                fails++;
                $display("FAIL engine_slave_bus cyc=%0d got rd=%b wr=%b a=%h wd=%h be=%h exp rd=%b wr=%b a=%h wd=%h be=%h",
                         cyc, read, write, address, writedata, byteenable, e_rd, e_wr, e_addr, e_wd, e_be);
            end
            tests++;
            if ({i_waitrequest, d_waitrequest} !== {e_iw, e_dw}) begin
                fails++;
                $display("FAIL engine_waitrequest cyc=%0d got i=%b d=%b exp i=%b d=%b",
                         cyc, i_waitrequest, d_waitrequest, e_iw, e_dw);
            end
            tests++;
            if ({i_readdatavalid, d_readdatavalid, i_readdata, d_readdata} !== {e_iv, e_dv, e_ird, e_drd}) begin
                fails++;
                $display("FAIL engine_readdata cyc=%0d got iv=%b dv=%b i=%h d=%h exp iv=%b dv=%b i=%h d=%h",
                         cyc, i_readdatavalid, d_readdatavalid, i_readdata, d_readdata, e_iv, e_dv, e_ird, e_drd);
            end
            tests++;
            if (i_waitrequest === 1'b0) dut_grants.push_back(0);
            if (d_waitrequest === 1'b0) dut_grants.push_back(1);
            // Advance the model across the coming edge
            if (rd >= 0) begin
                rd = -1;
            end else if (cur >= 0) begin
                if (!waitrequest) begin
                    t = head(cur);
                    if (cur == 0) q_i.delete(0); else q_d.delete(0);
                    act[cur] = 0;
                    rd = t.wr ? -1 : cur;
                    cur = -1;
                end
            end else if (act[0] || act[1]) begin
                if (act[0] && act[1]) cur = (mlast == 1) ? 0 : 1;
                else cur = act[0] ? 0 : 1;
                mlast = cur;
            end
            tick();
            cyc++;
        end
        if (cyc >= max_cycles) begin
            fails++;
            $display("FAIL engine_timeout got %0d cycles exp completion below %0d", cyc, max_cycles);
        end
        tests++;
        clear_masters();
        waitrequest = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if ({read, write, address, writedata, byteenable} !== 70'd0) begin
            fails++; $display("FAIL reset_slave_bus got rd=%b wr=%b a=%h exp all zero", read, write, address);
        end
        tests++;
        if ({i_waitrequest, d_waitrequest} !== 2'b11) begin
            fails++; $display("FAIL reset_waitrequest got %b%b exp 11", i_waitrequest, d_waitrequest);
        end
        tests++;
        if ({i_readdatavalid, d_readdatavalid} !== 2'b00) begin
            fails++; $display("FAIL reset_valid got %b%b exp 00", i_readdatavalid, d_readdatavalid);
        end
        tests++;
    endtask

    task automatic test_fetch_read();
        do_reset();
        i_read = 1; i_address = RESET_VECTOR; waitrequest = 0;
        #1;
        if ({i_waitrequest, read} !== 2'b10) begin
            fails++; $display("FAIL fetch_c1 got iw=%b rd=%b exp iw=1 rd=0", i_waitrequest, read);
        end
        tests++;
        tick(); #1;
        if ({read, write, address, i_waitrequest, d_waitrequest} !== {2'b10, RESET_VECTOR, 2'b01}) begin
            fails++; $display("FAIL fetch_c2 got rd=%b wr=%b a=%h iw=%b dw=%b exp rd=1 wr=0 a=%h iw=0 dw=1",
                              read, write, address, i_waitrequest, d_waitrequest, RESET_VECTOR);
        end
        tests++;
        tick();
        i_read = 0; readdata = 32'h3C02FFFF;
        #1;
        if ({i_readdatavalid, i_readdata, d_readdatavalid, read} !== {1'b1, 32'h3C02FFFF, 2'b00}) begin
            fails++; $display("FAIL fetch_c3 got iv=%b i=%h dv=%b rd=%b exp iv=1 i=3c02ffff dv=0 rd=0",
                              i_readdatavalid, i_readdata, d_readdatavalid, read);
        end
        tests++;
        tick(); #1;
        if ({i_readdatavalid, i_readdata} !== 33'd0) begin
            fails++; $display("FAIL fetch_c4 got iv=%b i=%h exp iv=0 i=0", i_readdatavalid, i_readdata);
        end
        tests++;
    endtask

    task automatic test_tie();
        do_reset();
        i_read = 1; i_address = 32'hBFC00004;
        d_write = 1; d_address = 32'hBFC00100; d_writedata = 32'hFFFF0000; d_byteenable = 4'hF;
        tick(); #1;
        if ({read, write, address, d_waitrequest} !== {2'b10, 32'hBFC00004, 1'b1}) begin
            fails++; $display("FAIL tie_first got rd=%b wr=%b a=%h dw=%b exp rd=1 wr=0 a=bfc00004 dw=1",
                              read, write, address, d_waitrequest);
        end
        tests++;
        tick();
        i_read = 0; readdata = 32'h12345678;
        tick(); #1;
        if ({write, d_waitrequest} !== 2'b01) begin
            fails++; $display("FAIL tie_idle got wr=%b dw=%b exp wr=0 dw=1", write, d_waitrequest);
        end
        tests++;
        tick(); #1;
        if ({read, write, address, writedata, byteenable, d_waitrequest} !==
            {2'b01, 32'hBFC00100, 32'hFFFF0000, 4'hF, 1'b0}) begin
            fails++; $display("FAIL tie_second got rd=%b wr=%b a=%h wd=%h be=%h dw=%b exp rd=0 wr=1 a=bfc00100 wd=ffff0000 be=f dw=0",
                              read, write, address, writedata, byteenable, d_waitrequest);
        end
        tests++;
        tick();
        d_write = 0;
        #1;
        if ({write, d_readdatavalid} !== 2'b00) begin
            fails++; $display("FAIL tie_after got wr=%b dv=%b exp 0 0", write, d_readdatavalid);
        end
        tests++;
    endtask

    task automatic test_contention();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            q_i.push_back(rand_txn(0));
            q_d.push_back(rand_txn(1));
        end
        run_engine(25, 1'b1, 500);
        if (dut_grants.size() != 8) begin
            fails++; $display("FAIL contention_count got %0d exp 8", dut_grants.size());
        end
        tests++;
        for (int k = 0; k < 8 && k < dut_grants.size(); k++) begin
            if (dut_grants[k] != (k % 2)) begin
                fails++; $display("FAIL contention_order idx=%0d got %0d exp %0d", k, dut_grants[k], k % 2);
            end
            tests++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        d_read = 1; d_address = 32'h0000_1000; waitrequest = 1;
        #1;
        if ({d_waitrequest, read} !== 2'b10) begin
            fails++; $display("FAIL stall_idle got dw=%b rd=%b exp dw=1 rd=0", d_waitrequest, read);
        end
        tests++;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            if ({read, write, address, d_waitrequest, d_readdatavalid} !== {2'b10, 32'h0000_1000, 2'b10}) begin
                fails++; $display("FAIL stall_hold k=%0d got rd=%b wr=%b a=%h dw=%b dv=%b exp rd=1 wr=0 a=00001000 dw=1 dv=0",
                                  k, read, write, address, d_waitrequest, d_readdatavalid);
            end
            tests++;
        end
        tick();
        waitrequest = 0;
        #1;
        if ({read, d_waitrequest} !== 2'b10) begin
            fails++; $display("FAIL stall_accept got rd=%b dw=%b exp rd=1 dw=0", read, d_waitrequest);
        end
        tests++;
        tick();
        d_read = 0; readdata = 32'hCAFE_F00D;
        #1;
        if ({d_readdatavalid, d_readdata, i_readdatavalid} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin
            fails++; $display("FAIL stall_data got dv=%b d=%h iv=%b exp dv=1 d=cafef00d iv=0",
                              d_readdatavalid, d_readdata, i_readdatavalid);
        end
        tests++;
        tick();
    endtask

    task automatic test_byte_write();
        do_reset();
        d_write = 1; d_address = 32'h0000_2002; d_writedata = 32'h0000AB00; d_byteenable = 4'b0010;
        tick();
        i_read = 1; i_address = RESET_VECTOR + 32'h8;
        #1;
        if ({write, byteenable, writedata, address, i_waitrequest} !== {1'b1, 4'b0010, 32'h0000AB00, 32'h0000_2002, 1'b1}) begin
            fails++; $display("FAIL byte_write got wr=%b be=%b wd=%h a=%h iw=%b exp wr=1 be=0010 wd=0000ab00 a=00002002 iw=1",
                              write, byteenable, writedata, address, i_waitrequest);
        end
        tests++;
        tick();
        d_write = 0;
        #1;
        if ({read, i_waitrequest} !== 2'b01) begin
            fails++; $display("FAIL byte_queued_idle got rd=%b iw=%b exp rd=0 iw=1", read, i_waitrequest);
        end
        tests++;
        tick(); #1;
        if ({read, address, i_waitrequest} !== {1'b1, RESET_VECTOR + 32'h8, 1'b0}) begin
            fails++; $display("FAIL byte_queued_grant got rd=%b a=%h iw=%b exp rd=1 a=%h iw=0",
                              read, address, i_waitrequest, RESET_VECTOR + 32'h8);
        end
        tests++;
        tick();
        i_read = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_read = 1; d_address = 32'h0000_3000; waitrequest = 1;
        tick(); #1;
        if (read !== 1'b1) begin
            fails++; $display("FAIL rmid_busy got rd=%b exp 1", read);
        end
        tests++;
        reset = 1;
        tick();
        reset = 0; waitrequest = 0;
        i_read = 1; i_address = RESET_VECTOR + 32'h10; d_address = 32'h0000_3004;
        #1;
        if ({read, write, d_waitrequest, i_waitrequest, d_readdatavalid} !== 5'b00110) begin
            fails++; $display("FAIL rmid_idle got rd=%b wr=%b dw=%b iw=%b dv=%b exp 0 0 1 1 0",
                              read, write, d_waitrequest, i_waitrequest, d_readdatavalid);
        end
        tests++;
        tick(); #1;
        if ({read, address, i_waitrequest, d_readdatavalid} !== {1'b1, RESET_VECTOR + 32'h10, 2'b00}) begin
            fails++; $display("FAIL rmid_tie got rd=%b a=%h iw=%b dv=%b exp rd=1 a=%h iw=0 dv=0",
                              read, address, i_waitrequest, d_readdatavalid, RESET_VECTOR + 32'h10);
        end
        tests++;
        tick();
        i_read = 0; readdata = 32'h0BAD_BEEF;
        #1;
        if ({i_readdatavalid, d_readdatavalid} !== 2'b10) begin
            fails++; $display("FAIL rmid_ivalid got iv=%b dv=%b exp iv=1 dv=0", i_readdatavalid, d_readdatavalid);
        end
        tests++;
        tick(); tick(); #1;
        if ({read, address, d_waitrequest} !== {1'b1, 32'h0000_3004, 1'b0}) begin
            fails++; $display("FAIL rmid_dgrant got rd=%b a=%h dw=%b exp rd=1 a=00003004 dw=0",
                              read, address, d_waitrequest);
        end
        tests++;
        tick();
        d_read = 0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            q_i.push_back(rand_txn(0));
            q_d.push_back(rand_txn(1));
        end
        run_engine(35, 1'b0, 3000);
        do_reset();
        for (int k = 0; k < 30; k++) begin
            q_i.push_back(rand_txn(0));
            if (k % 3 != 0) q_d.push_back(rand_txn(1));
        end
        run_engine(0, 1'b1, 3000);
    endtask

    initial begin
        reset = 0;
        clear_masters();
        waitrequest = 0;
        readdata = 0;
        test_reset();
        test_fetch_read();
        test_tie();
        test_contention();
        test_stall();
        test_byte_write();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
